busmux_n: RTL and testbench
===========================

Name: busmux_n

Overview:
- Parametrised successor to the fixed four-target register bus mux.
- Decodes one master strobe/ack bus onto NSLV external target ports, each with its own strobe/ack handshake.
- Routes read data back to the master from the selected target.
- Adds features the fixed mux lacks: unmapped-slot error responses, a per-transaction timeout, a busy indication, and a parity output on read data.
- Sits between the host bus bridge and the register-block clusters.

Parameters:
DATAW, 8, data width of master and target buses
ADDRW, 8, master address width
NSLV, 4, number of target ports (1..2**SELW)
SELLO, 4, LSB index of slot-select field in i_addr
SELW, 3, width of slot-select field; slot = i_addr[SELLO+SELW-1:SELLO]
TMO, 15, wait-state cycles before timeout (1..255)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_stb  in  1  master request, accepted only when o_busy=0
i_we  in  1  1=write, 0=read
i_addr  in  ADDRW  master address
i_data  in  DATAW  master write data
o_ack  out  1  single-cycle transaction completion
o_err  out  1  valid with o_ack; 1 = unmapped slot or timeout
o_data  out  DATAW  read data, valid with o_ack, held until next o_ack
o_par  out  1  XOR-reduction of o_data
o_busy  out  1  transaction in flight (state != IDLE)
o_s_stb  out  NSLV  one-hot target strobe, one cycle per transaction
o_s_we  out  1  latched i_we, broadcast to all targets
o_s_addr  out  SELLO  latched i_addr[SELLO-1:0]
o_s_data  out  DATAW  latched i_data
i_s_ack  in  NSLV  per-target ack
i_s_data  in  NSLV*DATAW  target read data; slot k at [k*DATAW +: DATAW]

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - o_ack, o_err, o_busy, o_s_stb and o_par all 0.
  - o_data=0.
  - o_s_we, o_s_addr, o_s_data and the timeout count all 0.
- Reset asserted mid-transaction aborts it. No o_ack is ever issued for the aborted request.
- States: IDLE, WAIT, RESP.
- IDLE:
  - When i_stb=1, latch we/addr/data/slot at the edge.
  - If slot >= NSLV: go to RESP with err=1. o_data is unchanged for writes and set to all-ones for reads. No o_s_stb is issued.
  - Otherwise: o_s_stb[slot]=1 for the next cycle only, clear the timeout count, and go to WAIT.
- WAIT:
  - Sample i_s_ack[slot] each edge, including the edge ending the o_s_stb cycle.
  - On ack: for reads, o_data <= i_s_data[slot]. For writes, o_data is unchanged. Then go to RESP with err=0.
  - With no ack, the count increments. When count==TMO with no ack: go to RESP with err=1, and set o_data to all-ones for reads.
  - If ack and timeout occur on the same edge, the ack wins (err=0).
  - Acks from non-selected targets are ignored in every state.
  - A late ack arriving after a timeout is ignored.
- RESP:
  - o_ack=1 and o_err valid for exactly one cycle.
  - o_par tracks o_data.
  - Next state is IDLE.
- Latency:
  - Unmapped slot: o_ack high in the cycle after the i_stb edge.
  - Immediate target ack: o_s_stb in cycle 1, o_ack in cycle 2.
  - Each extra target wait state adds one cycle.
  - Maximum latency is TMO+2 cycles.
- i_stb while o_busy=1 (WAIT or RESP) is ignored and not queued. The master must re-issue it.
- Back-to-back: a new i_stb is accepted on the first edge after RESP. Throughput is at most one transaction per 3 cycles.
- o_s_we, o_s_addr and o_s_data stay stable from the cycle of o_s_stb until the next accepted request.
- Count width is ceil(log2(TMO+1)). The count saturates and never wraps.

Decomposition:
- Package busmux_pkg:
  - state enum (IDLE/WAIT/RESP).
  - slot-decode function (addr, SELLO, SELW).
  - ERR_RDATA constant (all-ones).
- One sub-module, busmux_timer: clear/enable saturating counter with an expired flag, parametrised by TMO.

Test Plan:
- Read, slot 2 acks immediately, i_s_data slot2=8'hA5 -> o_s_stb=4'b0100 for one cycle; o_ack 2 cycles after i_stb edge; o_data=8'hA5, o_err=0, o_par=0.
- Write addr 8'h13, data 8'h3C, slot 1 acks after 3 wait cycles -> o_s_we=1, o_s_addr=4'h3, o_s_data=8'h3C; o_ack in cycle 5; o_err=0; o_data unchanged.
- Read addr 8'h50 (slot 5 >= NSLV=4) -> no o_s_stb; o_ack next cycle; o_err=1; o_data=8'hFF.
- Read slot 0 with no ack, TMO=15 -> o_ack at cycle 17; o_err=1; o_data=8'hFF. Ack at cycle 18 is ignored.
- i_stb held high continuously; slot 3 ack arrives on the same edge as timeout expiry -> o_err=0. Requests during o_busy are dropped; the next request is accepted the edge after o_ack.
- i_rst pulsed during WAIT -> all outputs 0 asynchronously; no o_ack follows; the next read completes normally.

Source files
------------

// File: rtl/busmux_pkg.sv
// Shared types and helpers for the parametrised register bus mux.
// Imported by the mux top and its timeout timer.
package busmux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Wide all-ones pattern; users slice it down to their data width.
  localparam logic [255:0] ERR_RDATA = '1;

  function automatic int unsigned slot_of(
    input logic [31:0] addr,
    input int          sello,
    input int          selw
  );
    logic [31:0] mask;
    mask = (32'd1 << selw) - 32'd1;
    return (addr >> sello) & mask;
  endfunction

endpackage

// File: rtl/busmux_timer.sv
// Saturating wait-state counter with clear/enable and an expired flag.
// Holds at TMO once reached; never wraps.
module busmux_timer
  import busmux_pkg::*;
#(
  parameter int TMO = 15,
  parameter int CW  = $clog2(TMO + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic          o_expired,
  output logic [CW-1:0] o_count
);

  assign o_expired = (o_count == CW'(TMO));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= '0;
    end else if (i_en && !o_expired) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/busmux_n.sv
// Register bus mux: one master strobe/ack bus onto NSLV target ports,
// with unmapped-slot errors, timeout, busy flag and read-data parity.
module busmux_n
  import busmux_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int ADDRW = 8,
  parameter int NSLV  = 4,
  parameter int SELLO = 4,
  parameter int SELW  = 3,
  parameter int TMO   = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic [ADDRW-1:0]      i_addr,
  input  logic [DATAW-1:0]      i_data,
  output logic                  o_ack,
  output logic                  o_err,
  output logic [DATAW-1:0]      o_data,
  output logic                  o_par,
  output logic                  o_busy,
  output logic [NSLV-1:0]       o_s_stb,
  output logic                  o_s_we,
  output logic [SELLO-1:0]      o_s_addr,
  output logic [DATAW-1:0]      o_s_data,
  input  logic [NSLV-1:0]       i_s_ack,
  input  logic [NSLV*DATAW-1:0] i_s_data
);

  localparam int CW = $clog2(TMO + 1);
  localparam logic [DATAW-1:0] ERR_D =
    ERR_RDATA[DATAW-1:0];

  state_t            state;
  logic [SELW-1:0]   slot_q;
  int unsigned       in_slot;
  logic              mapped;
  logic              accept;
  logic [NSLV-1:0]   stb_d;
  logic              sel_ack;
  logic [DATAW-1:0]  sel_rdata;
  logic              expired;
  logic [CW-1:0]     count;

  assign in_slot = slot_of(32'(i_addr), SELLO, SELW);
  assign mapped  = (in_slot < NSLV);
  assign accept  = (state == IDLE) && i_stb;
  assign o_busy  = (state != IDLE);
  assign o_par   = ^o_data;

  always_comb begin
    stb_d = '0;
    for (int k = 0; k < NSLV; k++) begin
      stb_d[k] = (in_slot == k);
    end
  end

  // Only the latched slot is ever looked at; other acks are ignored.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (slot_q == SELW'(k)) begin
        sel_ack   = i_s_ack[k];
        sel_rdata = i_s_data[k*DATAW +: DATAW];
      end
    end
  end

  busmux_timer #(
    .TMO (TMO),
    .CW  (CW)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (accept),
    .i_en      (state == WAIT),
    .o_expired (expired),
    .o_count   (count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      slot_q   <= '0;
      o_ack    <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      o_s_stb  <= '0;
      o_s_we   <= 1'b0;
      o_s_addr <= '0;
      o_s_data <= '0;
    end else begin
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_s_stb <= '0;
      unique case (state)
        IDLE: begin
          if (i_stb) begin
            o_s_we   <= i_we;
            o_s_addr <= i_addr[SELLO-1:0];
            o_s_data <= i_data;
            slot_q   <= SELW'(in_slot);
            if (!mapped) begin
              state <= RESP;
              o_ack <= 1'b1;
              o_err <= 1'b1;
              if (!i_we) o_data <= ERR_D;
            end else begin
              state   <= WAIT;
              o_s_stb <= stb_d;
            end
          end
        end
        WAIT: begin
          if (sel_ack) begin
            state <= RESP;
            o_ack <= 1'b1;
            if (!o_s_we) o_data <= sel_rdata;
          end else if (expired) begin
            state <= RESP;
            o_ack <= 1'b1;
            o_err <= 1'b1;
            if (!o_s_we) o_data <= ERR_D;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_busmux_n.sv
// Scoreboard bench for busmux_n: expectations queued at request time,
// popped and compared when o_ack appears.
module tb_busmux_n;

  localparam int DATAW = 8;
  localparam int ADDRW = 8;
  localparam int NSLV  = 4;
  localparam int SELLO = 4;
  localparam int SELW  = 3;
  localparam int TMO   = 15;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_stb;
  logic                  i_we;
  logic [ADDRW-1:0]      i_addr;
  logic [DATAW-1:0]      i_data;
  logic                  o_ack;
  logic                  o_err;
  logic [DATAW-1:0]      o_data;
  logic                  o_par;
  logic                  o_busy;
  logic [NSLV-1:0]       o_s_stb;
  logic                  o_s_we;
  logic [SELLO-1:0]      o_s_addr;
  logic [DATAW-1:0]      o_s_data;
  logic [NSLV-1:0]       i_s_ack;
  logic [NSLV*DATAW-1:0] i_s_data;

  busmux_n #(
    .DATAW (DATAW),
    .ADDRW (ADDRW),
    .NSLV  (NSLV),
    .SELLO (SELLO),
    .SELW  (SELW),
    .TMO   (TMO)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stb    (i_stb),
    .i_we     (i_we),
    .i_addr   (i_addr),
    .i_data   (i_data),
    .o_ack    (o_ack),
    .o_err    (o_err),
    .o_data   (o_data),
    .o_par    (o_par),
    .o_busy   (o_busy),
    .o_s_stb  (o_s_stb),
    .o_s_we   (o_s_we),
    .o_s_addr (o_s_addr),
    .o_s_data (o_s_data),
    .i_s_ack  (i_s_ack),
    .i_s_data (i_s_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] sdata [NSLV] = '{8'h11, 8'h5A, 8'hA5, 8'h77};

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic txn(
    input string      tag,
    input logic       we,
    input logic [7:0] addr,
    input logic [7:0] data,
    input int         d,
    input bit         noise,
    input bit         hold
  );
    int         slot;
    bit         mapped;
    bit         done;
    logic [3:0] onehot;
    logic [3:0] a;
    exp_t       e;
    exp_t       x;
    slot   = int'(addr[6:4]);
    mapped = (slot < NSLV);
    done   = 1'b0;
    onehot = mapped ? 4'(1 << slot) : 4'b0;
    if (!mapped) begin
      e.err  = 1'b1;
      e.lat  = 1;
      e.data = we ? model_data : 8'hFF;
    end else if (d >= 0 && d <= TMO) begin
      e.err  = 1'b0;
      e.lat  = 2 + d;
      e.data = we ? model_data : sdata[slot];
    end else begin
      e.err  = 1'b1;
      e.lat  = TMO + 2;
      e.data = we ? model_data : 8'hFF;
    end
    model_data = e.data;
    sb.push_back(e);
    i_stb  = 1'b1;
    i_we   = we;
    i_addr = addr;
    i_data = data;
    tick;
    if (!hold) i_stb = 1'b0;
    for (int cyc = 1; cyc <= TMO + 5 && !done; cyc++) begin
      a = (noise && mapped) ? ~onehot : 4'b0;
      if (mapped && cyc == 1 + d) a = a | onehot;
      i_s_ack = a;
      if (cyc == 1) begin
        chk({tag, " stb"}, 32'(o_s_stb), 32'(onehot));
        chk({tag, " busy"}, 32'(o_busy), 32'd1);
        if (mapped) begin
          chk({tag, " s_we"}, 32'(o_s_we), 32'(we));
          chk({tag, " s_addr"}, 32'(o_s_addr), 32'(addr[3:0]));
          chk({tag, " s_data"}, 32'(o_s_data), 32'(data));
        end
      end else begin
        chk({tag, " stb0"}, 32'(o_s_stb), 32'd0);
      end
      if (o_ack) begin
        x = sb.pop_front();
        chk({tag, " lat"}, 32'(cyc), 32'(x.lat));
        chk({tag, " err"}, 32'(o_err), 32'(x.err));
        chk({tag, " data"}, 32'(o_data), 32'(x.data));
        chk({tag, " par"}, 32'(o_par), 32'(^x.data));
        done = 1'b1;
      end else begin
        tick;
      end
    end
    i_s_ack = '0;
    chk({tag, " done"}, 32'(done), 32'd1);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    i_rst   = 1'b1;
    i_stb   = 1'b0;
    i_we    = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    i_s_ack = '0;
    for (int k = 0; k < NSLV; k++) begin
      i_s_data[k*DATAW +: DATAW] = sdata[k];
    end
    tick;
    tick;
    chk("rst ack", 32'(o_ack), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst stb", 32'(o_s_stb), 32'd0);
    chk("rst data", 32'(o_data), 32'd0);
    chk("rst s_addr", 32'(o_s_addr), 32'd0);
    i_rst = 1'b0;
    tick;

    txn("rd2", 1'b0, 8'h20, 8'h00, 0, 1'b0, 1'b0);
    txn("wr1", 1'b1, 8'h13, 8'h3C, 3, 1'b1, 1'b0);
    txn("rdunm", 1'b0, 8'h50, 8'h00, 0, 1'b0, 1'b0);
    txn("wrunm", 1'b1, 8'h70, 8'h99, 0, 1'b0, 1'b0);
    txn("rd1", 1'b0, 8'h1F, 8'h00, 2, 1'b0, 1'b0);
    txn("tmo0", 1'b0, 8'h00, 8'h00, -1, 1'b1, 1'b0);

    // Late ack from the timed-out target must not produce a response.
    i_s_ack = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      chk("late ack", 32'(o_ack), 32'd0);
      chk("late busy", 32'(o_busy), 32'd0);
      tick;
    end
    i_s_ack = '0;

    txn("hold3", 1'b0, 8'h30, 8'h00, TMO, 1'b1, 1'b1);
    chk("b2b idle", 32'(o_busy), 32'd0);
    txn("b2b2", 1'b0, 8'h2A, 8'h00, 0, 1'b0, 1'b0);

    // Abort a read mid-wait with an asynchronous reset.
    txn_abort();

    txn("post", 1'b0, 8'h21, 8'h00, 1, 1'b0, 1'b0);

    chk("sb empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  task automatic txn_abort;
    exp_t e;
    e.err  = 1'b0;
    e.lat  = 2;
    e.data = sdata[1];
    sb.push_back(e);
    i_stb  = 1'b1;
    i_we   = 1'b0;
    i_addr = 8'h10;
    tick;
    i_stb = 1'b0;
    tick;
    tick;
    chk("abort busy", 32'(o_busy), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst ack", 32'(o_ack), 32'd0);
    chk("arst busy", 32'(o_busy), 32'd0);
    chk("arst data", 32'(o_data), 32'd0);
    chk("arst par", 32'(o_par), 32'd0);
    chk("arst s_we", 32'(o_s_we), 32'd0);
    sb.delete();
    model_data = 8'h00;
    tick;
    i_rst   = 1'b0;
    i_s_ack = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      chk("abort noack", 32'(o_ack), 32'd0);
      tick;
    end
    i_s_ack = '0;
  endtask

endmodule
